// File: rtl/pdm_deserializer_if.sv
// Word handshake between the PDM deserializer (master) and its consumer (slave).
interface pdm_deserializer_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] DATA;
  logic                  VALID;
  logic                  ACK;
  logic                  OVERRUN;

  modport master (output DATA, output VALID, output OVERRUN, input ACK);
  modport slave  (input DATA, input VALID, input OVERRUN, output ACK);
endinterface

// File: rtl/pdm_deserializer.sv
// PDM microphone capture: generates PDM_CLK, samples PDM_DATA on its rising edge, packs words MSB-first.
// Optional sticky overrun detection is built when PDM_DESERIALIZER_OVERRUN_EN is defined.
module pdm_deserializer #(
  parameter int DATA_WIDTH           = 16,
  parameter int SYS_CLK_FREQ_MHZ     = 100,
  parameter int SAMPLING_CLK_FREQ_HZ = 44100
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  EN,
  output logic                  PDM_CLK,
  output logic                  PDM_LRSEL,
  input  logic                  PDM_DATA,
  pdm_deserializer_if.master    bus
);

  localparam int HALF_DIV = (SYS_CLK_FREQ_MHZ * 1000000) /
                            (2 * SAMPLING_CLK_FREQ_HZ * DATA_WIDTH) - 1;
  localparam int CNT_W = (HALF_DIV < 1) ? 1 : $clog2(HALF_DIV + 1);
  localparam int BIT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] HALF_DIV_C = CNT_W'(HALF_DIV);
  localparam logic [BIT_W-1:0] LAST_BIT_C = BIT_W'(DATA_WIDTH - 1);

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  pdm_clk_q, pdm_clk_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [DATA_WIDTH-2:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  sync1_q, sync2_q;
  logic                  rise_s;
  logic                  complete_s;
  logic [DATA_WIDTH-1:0] new_word_s;

  assign rise_s     = (cnt_q == HALF_DIV_C) && !pdm_clk_q;
  assign complete_s = rise_s && (bit_q == LAST_BIT_C);
  assign new_word_s = {shift_q, sync2_q};

  // Two-stage synchronizer for the asynchronous microphone bit; unaffected by EN.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= PDM_DATA;
      sync2_q <= sync1_q;
    end
  end

  // Next-state logic for clock divider, bit packing and the word handshake.
  always_comb begin
    cnt_d     = cnt_q;
    pdm_clk_d = pdm_clk_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = valid_q;
    if (!EN) begin
      cnt_d     = {CNT_W{1'b0}};
      pdm_clk_d = 1'b0;
      bit_d     = {BIT_W{1'b0}};
      shift_d   = {(DATA_WIDTH-1){1'b0}};
      data_d    = {DATA_WIDTH{1'b0}};
      valid_d   = 1'b0;
    end else begin
      if (cnt_q == HALF_DIV_C) begin
        cnt_d     = {CNT_W{1'b0}};
        pdm_clk_d = ~pdm_clk_q;
      end else begin
        cnt_d     = cnt_q + CNT_W'(1);
        pdm_clk_d = pdm_clk_q;
      end
      if (rise_s) begin
        shift_d = new_word_s[DATA_WIDTH-2:0];
      end else begin
        shift_d = shift_q;
      end
      // A completion wins over a same-edge ACK: the fresh word stays valid.
      if (complete_s) begin
        bit_d   = {BIT_W{1'b0}};
        data_d  = new_word_s;
        valid_d = 1'b1;
      end else if (rise_s) begin
        bit_d   = bit_q + BIT_W'(1);
        data_d  = data_q;
        valid_d = valid_q && !bus.ACK;
      end else begin
        bit_d   = bit_q;
        data_d  = data_q;
        valid_d = valid_q && !bus.ACK;
      end
    end
  end

  // Capture-path state registers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      cnt_q     <= {CNT_W{1'b0}};
      pdm_clk_q <= 1'b0;
      bit_q     <= {BIT_W{1'b0}};
      shift_q   <= {(DATA_WIDTH-1){1'b0}};
      data_q    <= {DATA_WIDTH{1'b0}};
      valid_q   <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      pdm_clk_q <= pdm_clk_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
    end
  end

`ifdef PDM_DESERIALIZER_OVERRUN_EN
  logic overrun_q, overrun_d;

  // Sticky overrun: a word lands while the previous one is still unacknowledged.
  always_comb begin
    overrun_d = overrun_q;
    if (!EN) begin
      overrun_d = 1'b0;
    end else if (complete_s && valid_q && !bus.ACK) begin
      overrun_d = 1'b1;
    end else begin
      overrun_d = overrun_q;
    end
  end

  // Overrun flag register.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= overrun_d;
    end
  end

  assign bus.OVERRUN = overrun_q;
`else
  assign bus.OVERRUN = 1'b0;
`endif

  assign PDM_CLK   = pdm_clk_q;
  assign PDM_LRSEL = 1'b0;
  assign bus.DATA  = data_q;
  assign bus.VALID = valid_q;

endmodule

// File: tb/tb_pdm_deserializer.sv
// Directed bench for pdm_deserializer: table-driven word stream plus EN-drop and reset sequences.
module tb_pdm_deserializer;

  logic HCLK;
  logic HRESETn;
  logic EN;
  logic PDM_CLK;
  logic PDM_LRSEL;
  logic PDM_DATA;

  int n_chk  = 0;
  int n_fail = 0;
  int edge_n = 0;

`ifdef PDM_DESERIALIZER_OVERRUN_EN
  localparam logic OVR_EXP = 1'b1;
`else
  localparam logic OVR_EXP = 1'b0;
`endif

  pdm_deserializer_if #(.DATA_WIDTH(16)) bus ();

  pdm_deserializer #(
    .DATA_WIDTH(16),
    .SYS_CLK_FREQ_MHZ(100),
    .SAMPLING_CLK_FREQ_HZ(44100)
  ) dut (
    .HCLK(HCLK),
    .HRESETn(HRESETn),
    .EN(EN),
    .PDM_CLK(PDM_CLK),
    .PDM_LRSEL(PDM_LRSEL),
    .PDM_DATA(PDM_DATA),
    .bus(bus)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [15:0] word;
    int          ack_mode;   // 0 none, 1 pulse 10 cycles after VALID, 2 ACK on the completion edge
    logic [15:0] exp_data;
    logic        exp_valid;
    logic        exp_ovr;
    logic        exp_valid_after;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // Advance to 1 time unit after the target HCLK edge (edge 1 = first edge with EN high).
  task automatic goto_edge(input int tgt);
    while (edge_n < tgt) begin
      @(posedge HCLK);
      #1;
      edge_n++;
    end
  endtask

  task automatic start_run();
    edge_n = 0;
    EN = 1'b1;
  endtask

  // Present bits n0..n0+nbits-1 of the stream, each 65 cycles before its capture edge.
  task automatic send_bits(input logic [15:0] w, input int n0, input int nbits);
    for (int b = 0; b < nbits; b++) begin
      goto_edge(5 + 140 * (n0 + b));
      PDM_DATA = w[15-b];
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_pdm_clk"}, {31'd0, PDM_CLK}, 32'd0);
    chk({tag, "_data"}, {16'd0, bus.DATA}, 32'd0);
    chk({tag, "_valid"}, {31'd0, bus.VALID}, 32'd0);
    chk({tag, "_overrun"}, {31'd0, bus.OVERRUN}, 32'd0);
  endtask

  initial begin
    int e;
    vecs[0] = '{16'hFFFF, 1, 16'hFFFF, 1'b1, 1'b0,    1'b0};
    vecs[1] = '{16'hAAAA, 1, 16'hAAAA, 1'b1, 1'b0,    1'b0};
    vecs[2] = '{16'hAAAA, 1, 16'hAAAA, 1'b1, 1'b0,    1'b0};
    vecs[3] = '{16'h0F0F, 0, 16'h0F0F, 1'b1, 1'b0,    1'b1};
    vecs[4] = '{16'h3C3C, 2, 16'h3C3C, 1'b1, 1'b0,    1'b1};
    vecs[5] = '{16'h8001, 0, 16'h8001, 1'b1, OVR_EXP, 1'b1};
    vecs[6] = '{16'h5A5A, 1, 16'h5A5A, 1'b1, OVR_EXP, 1'b0};
    vecs[7] = '{16'h1234, 1, 16'h1234, 1'b1, OVR_EXP, 1'b0};

    HRESETn  = 1'b0;
    EN       = 1'b0;
    PDM_DATA = 1'b0;
    bus.ACK  = 1'b0;
    repeat (3) @(posedge HCLK);
    #1;
    chk_outputs_zero("reset");
    chk("reset_lrsel", {31'd0, PDM_LRSEL}, 32'd0);
    HRESETn = 1'b1;
    repeat (2) @(posedge HCLK);
    #1;

    // Constant-1 stream: divider timing and first completion at edge 2170.
    PDM_DATA = 1'b1;
    start_run();
    goto_edge(69);   chk("clk_e69",  {31'd0, PDM_CLK}, 32'd0);
    goto_edge(70);   chk("clk_e70",  {31'd0, PDM_CLK}, 32'd1);
    goto_edge(139);  chk("clk_e139", {31'd0, PDM_CLK}, 32'd1);
    goto_edge(140);  chk("clk_e140", {31'd0, PDM_CLK}, 32'd0);
    goto_edge(210);  chk("clk_e210", {31'd0, PDM_CLK}, 32'd1);
    goto_edge(2169); chk("ones_valid_pre", {31'd0, bus.VALID}, 32'd0);
    goto_edge(2170);
    chk("ones_valid", {31'd0, bus.VALID}, 32'd1);
    chk("ones_data", {16'd0, bus.DATA}, 32'h0000FFFF);
    chk("ones_overrun", {31'd0, bus.OVERRUN}, 32'd0);
    EN = 1'b0;
    goto_edge(2172);
    chk_outputs_zero("en_clear1");

    // Table-driven continuous word stream.
    start_run();
    for (int i = 0; i < 8; i++) begin
      send_bits(vecs[i].word, 16 * i, 16);
      e = 70 + 140 * (16 * i + 15);
      if (vecs[i].ack_mode == 2) begin
        goto_edge(e - 1);
        bus.ACK = 1'b1;
        goto_edge(e);
        bus.ACK = 1'b0;
      end else begin
        goto_edge(e);
      end
      chk($sformatf("vec%0d_data", i), {16'd0, bus.DATA}, {16'd0, vecs[i].exp_data});
      chk($sformatf("vec%0d_valid", i), {31'd0, bus.VALID}, {31'd0, vecs[i].exp_valid});
      chk($sformatf("vec%0d_overrun", i), {31'd0, bus.OVERRUN}, {31'd0, vecs[i].exp_ovr});
      if (vecs[i].ack_mode == 1) begin
        goto_edge(e + 10);
        chk($sformatf("vec%0d_valid_preack", i), {31'd0, bus.VALID}, 32'd1);
        bus.ACK = 1'b1;
        goto_edge(e + 11);
        bus.ACK = 1'b0;
        chk($sformatf("vec%0d_valid_postack", i), {31'd0, bus.VALID},
            {31'd0, vecs[i].exp_valid_after});
        chk($sformatf("vec%0d_ovr_postack", i), {31'd0, bus.OVERRUN}, {31'd0, vecs[i].exp_ovr});
      end else begin
        goto_edge(e + 11);
        chk($sformatf("vec%0d_valid_hold", i), {31'd0, bus.VALID},
            {31'd0, vecs[i].exp_valid_after});
        chk($sformatf("vec%0d_data_hold", i), {16'd0, bus.DATA}, {16'd0, vecs[i].exp_data});
      end
    end
    EN = 1'b0;
    goto_edge(edge_n + 1);
    chk_outputs_zero("en_clear2");

    // Partial word of 7 bits discarded by EN drop; next word 2170 edges after re-enable.
    start_run();
    send_bits(16'hFFFF, 0, 7);
    goto_edge(950);
    EN = 1'b0;
    goto_edge(952);
    chk_outputs_zero("partial");
    start_run();
    send_bits(16'hC3A5, 0, 16);
    goto_edge(2169); chk("reen_valid_pre", {31'd0, bus.VALID}, 32'd0);
    goto_edge(2170);
    chk("reen_valid", {31'd0, bus.VALID}, 32'd1);
    chk("reen_data", {16'd0, bus.DATA}, 32'h0000C3A5);

    // Asynchronous reset mid-word while VALID is high.
    send_bits(16'hFFFF, 16, 4);
    goto_edge(2170 + 700);
    #3;
    HRESETn = 1'b0;
    #1;
    chk_outputs_zero("async_rst");
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    start_run();
    send_bits(16'h6B2D, 0, 16);
    goto_edge(2169); chk("post_rst_valid_pre", {31'd0, bus.VALID}, 32'd0);
    goto_edge(2170);
    chk("post_rst_valid", {31'd0, bus.VALID}, 32'd1);
    chk("post_rst_data", {16'd0, bus.DATA}, 32'h00006B2D);
    chk("post_rst_overrun", {31'd0, bus.OVERRUN}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pdm_deserializer.md
# pdm_deserializer

PDM microphone front end: generates the microphone bit clock, samples the 1-bit PDM stream on each rising edge, and packs DATA_WIDTH consecutive bits MSB-first into a parallel word. It presents each word on a valid/ack handshake. It is the capture-side counterpart of the PDM audio output path and runs at the same bit rate, SAMPLING_CLK_FREQ_HZ × DATA_WIDTH. A downstream filter or processor consumes the words.

## Interface
- DATA_WIDTH, 16: bits per packed word (≥2).
- SYS_CLK_FREQ_MHZ, 100: HCLK frequency in MHz.
- SAMPLING_CLK_FREQ_HZ, 44100: word rate in Hz. Bit rate is SAMPLING_CLK_FREQ_HZ × DATA_WIDTH.
- HCLK  input  1  system clock; all logic on rising edge.
- HRESETn  input  1  asynchronous, active-low reset.
- EN  input  1  enable; low = synchronous clear of all state (see Operation).
- PDM_CLK  output  1  microphone clock, registered, 50% duty.
- PDM_LRSEL  output  1  microphone channel select; constant 0 (data valid at PDM_CLK rising edge).
- PDM_DATA  input  1  asynchronous PDM bit from the microphone.
- DATA  output  DATA_WIDTH  last completed word; first-received bit is in the MSB.
- VALID  output  1  DATA holds an unacknowledged word.
- ACK  input  1  consumer accepts DATA when VALID & ACK.
- OVERRUN  output  1  sticky: a word completed while the previous one was unacknowledged.

## Operation
- HALF_DIV = (SYS_CLK_FREQ_MHZ×1000000)/(2×SAMPLING_CLK_FREQ_HZ×DATA_WIDTH) − 1, using integer division. The default is 69, giving a PDM_CLK period of 140 HCLK cycles (≈714.3 kHz).
- Half-period counter runs 0..HALF_DIV. At HALF_DIV it wraps to 0 and PDM_CLK toggles.
- Rise strobe: the edge where the counter is at HALF_DIV and PDM_CLK is 0, so PDM_CLK goes 0→1 on that edge.
- PDM_DATA passes through a 2-flop synchronizer (sync2). Only sync2 is sampled.
- On each rise strobe:
  - shift register ← {shift[DATA_WIDTH-2:0], sync2}.
  - bit counter increments 0..DATA_WIDTH-1.
- Word completion: a rise strobe with bit counter = DATA_WIDTH-1.
  - DATA ← {shift[DATA_WIDTH-2:0], sync2}.
  - VALID ← 1.
  - bit counter ← 0.
- Handshake:
  - VALID & ACK on an edge with no completion clears VALID.
  - Completion on the same edge as VALID & ACK: new DATA loads, VALID stays 1, no overrun.
  - ACK while VALID=0 is ignored.
- Overrun: completion while VALID=1 and ACK=0.
  - DATA is overwritten with the newer word and VALID stays 1.
  - OVERRUN behaviour is set by the macro (see Configuration).
- EN=0, sampled on an HCLK edge, synchronously clears:
  - half-period counter, PDM_CLK, bit counter, shift register, DATA, VALID and OVERRUN, all to 0.
  - The synchronizer keeps running.
- When EN returns to 1, capture restarts from bit 0.
- Reset values (HRESETn low, asynchronous): PDM_CLK=0, PDM_LRSEL=0, DATA=0, VALID=0, OVERRUN=0, and all counters, synchronizer and shift register at 0.
- A reset or EN drop mid-word discards the partial word and produces no VALID.

## Timing
- EN rises; call the first HCLK edge with EN=1 edge 1. PDM_CLK rises at edges 70, 210, 350, … (every 140 cycles).
- Bit k (k=1..DATA_WIDTH) is captured at edge 70+140(k−1).
- First VALID is high after edge 2170. Subsequent completions follow every 2240 HCLK cycles.
- Input-to-sample latency: PDM_DATA must be stable for at least 3 HCLK cycles before the rising PDM_CLK edge, which covers the 2 synchronizer stages plus 1 setup cycle. The microphone's falling-edge launch gives 70 cycles of margin.
- VALID clears on the edge after the cycle in which ACK is seen. DATA is stable for the whole time VALID is high unless an overrun occurs.

## Configuration
- Macro PDM_DESERIALIZER_OVERRUN_EN.
- Defined: OVERRUN sets on the overrun edge and stays 1 until EN=0 or HRESETn low. ACK does not clear it.
- Undefined: OVERRUN is tied to 0 and no detection logic is built. DATA overwrite and VALID behaviour are unchanged.

## Test plan
- PDM_DATA held 1 and EN raised, no ACK → VALID rises after edge 2170 with DATA=0xFFFF; PDM_CLK period is 140 cycles, high 70.
- PDM_DATA = 1,0,1,0,… changed 5 cycles after each PDM_CLK fall, with ACK pulsed 10 cycles after each VALID rise → successive words are 0xAAAA; VALID drops 1 cycle after ACK.
- Two words with no ACK, macro defined → the second completion overwrites DATA, VALID stays 1, and OVERRUN=1 until EN is pulsed low. With the macro undefined, OVERRUN stays 0.
- ACK asserted on exactly the edge of the second completion → DATA updates, VALID stays 1, OVERRUN=0.
- EN dropped after 7 bits, then re-raised → no VALID for the partial word, and the next word completes 2170 cycles after re-enable.
- HRESETn asserted mid-word with VALID=1 → all outputs go 0 immediately (asynchronously); capture resumes cleanly after release.
